// File: rtl/asic_printer_sink.sv
// -----------------------------------------------------------------------------
// asic_printer_sink
//
// Printer-side end of a Centronics-style parallel port. A rising edge on
// printer_strobe marks a new byte on printer_data. The byte is pushed into a
// first-word-fallthrough FIFO. printer_busy is then held for BUSY_HOLD cycles,
// followed by a printer_ack pulse of ACK_CYCLES cycles. If the FIFO is full when
// a byte arrives, the byte is parked in hold_q and busy stays high until a slot
// frees up. Captured bytes leave the block on a valid/ready stream.
//
// Ports
//   clk_sys         in   system clock, all logic on the rising edge
//   reset           in   synchronous, active-high reset
//   printer_data    in   [7:0] byte from the ASIC, stable while strobe is high
//   printer_strobe  in   strobe level; a rising edge marks a new byte
//   printer_busy    out  high while the sink cannot take a byte
//   printer_ack     out  acknowledge pulse
//   out_data        out  [7:0] FIFO head byte
//   out_valid       out  FIFO non-empty
//   out_ready       in   consumer pop request
//   fifo_level      out  [$clog2(DEPTH):0] FIFO entry count, 0..DEPTH
//   overflow        out  sticky flag: strobe edge seen while not IDLE
//   clear_overflow  in   clears overflow (a new violation in the same cycle wins)
//   state_dbg       out  [1:0] FSM state (0 IDLE, 1 WAIT_SPACE, 2 BUSY, 3 ACK)
//
// Output stream handshake: a byte transfers on every rising clk_sys edge where
// out_valid and out_ready are both high. out_data is stable while out_valid is
// high and no transfer has happened. out_ready is ignored while out_valid is low.
// -----------------------------------------------------------------------------
module asic_printer_sink #(
   parameter int DEPTH      = 16,
   parameter int BUSY_HOLD  = 2,
   parameter int ACK_CYCLES = 4
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   input  logic [7:0]               printer_data,
   input  logic                     printer_strobe,
   output logic                     printer_busy,
   output logic                     printer_ack,
   output logic [7:0]               out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   input  logic                     clear_overflow,
   output logic [1:0]               state_dbg
);

   localparam int AW      = $clog2(DEPTH);
   localparam int LW      = AW + 1;
   localparam int CNT_MAX = (BUSY_HOLD > ACK_CYCLES) ? BUSY_HOLD : ACK_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] BUSY_INIT = CW'(BUSY_HOLD - 1);
   localparam logic [CW-1:0] ACK_INIT  = CW'(ACK_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_WAIT_SPACE = 2'd1,
      S_BUSY       = 2'd2,
      S_ACK        = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            strobe_prev_q, strobe_prev_d;
   logic [7:0]      hold_q, hold_d;
   logic            busy_q, busy_d;
   logic            ack_q, ack_d;
   logic            overflow_q, overflow_d;

   logic [7:0]      mem_q [DEPTH];
   logic [7:0]      mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            valid_q, valid_d;

   logic            strobe_rise;
   logic            full;
   logic            push;
   logic            pop;
   logic [7:0]      push_data;

   // Edge detect; strobe_prev resets to 1 so a strobe already high when reset
   // is released is not mistaken for a new byte.
   assign strobe_rise = printer_strobe & ~strobe_prev_q;
   // Full is judged on the registered count, so a pop in the same cycle does
   // not make room until the following cycle.
   assign full        = (level_q == LW'(DEPTH));
   assign pop         = valid_q & out_ready;

   // ---------------------------------------------------------------------------
   // FSM next state and transfer control
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      hold_d        = hold_q;
      push          = 1'b0;
      push_data     = printer_data;
      strobe_prev_d = printer_strobe;

      case (state_q)
         S_IDLE: begin
            if (strobe_rise) begin
               hold_d = printer_data;
               if (!full) begin
                  push    = 1'b1;
                  state_d = S_BUSY;
                  cnt_d   = BUSY_INIT;
               end else begin
                  state_d = S_WAIT_SPACE;
               end
            end
         end
         S_WAIT_SPACE: begin
            if (!full) begin
               push      = 1'b1;
               push_data = hold_q;
               state_d   = S_BUSY;
               cnt_d     = BUSY_INIT;
            end
         end
         S_BUSY: begin
            if (cnt_q == '0) begin
               state_d = S_ACK;
               cnt_d   = ACK_INIT;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_ACK: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      busy_d = (state_d == S_BUSY) || (state_d == S_WAIT_SPACE);
      ack_d  = (state_d == S_ACK);

      // Any strobe edge outside IDLE is dropped and flagged; set beats clear.
      overflow_d = overflow_q;
      if (clear_overflow) begin
         overflow_d = 1'b0;
      end
      if (strobe_rise && (state_q != S_IDLE)) begin
         overflow_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO next state
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
      end
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + LW'(push) - LW'(pop);
      valid_d  = (level_d != '0);
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_sys) begin
      mem_q <= mem_d;
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         strobe_prev_q <= 1'b1;
         hold_q        <= '0;
         busy_q        <= 1'b0;
         ack_q         <= 1'b0;
         overflow_q    <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         valid_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         strobe_prev_q <= strobe_prev_d;
         hold_q        <= hold_d;
         busy_q        <= busy_d;
         ack_q         <= ack_d;
         overflow_q    <= overflow_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         valid_q       <= valid_d;
      end
   end

   assign printer_busy = busy_q;
   assign printer_ack  = ack_q;
   // Head byte read straight from the storage flops at the registered pointer.
   assign out_data     = mem_q[rd_ptr_q];
   assign out_valid    = valid_q;
   assign fifo_level   = level_q;
   assign overflow     = overflow_q;
   assign state_dbg    = state_q;

endmodule
